pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor_if.sv | 29 ++
 rtl/pll_lock_supervisor.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// ============================================================================
//  Module   : pll_lock_supervisor_if
//  Brief    : Lock-request inputs and status outputs of the PLL lock supervisor.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface pll_lock_supervisor_if;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_resetb;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    modport master (
        output pll_lock, relock_req,
        input  pll_resetb, sys_rst_n, locked, fault, retry_cnt, state
    );

    modport slave (
        input  pll_lock, relock_req,
        output pll_resetb, sys_rst_n, locked, fault, retry_cnt, state
    );
endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
//  Module   : pll_lock_supervisor
//  Brief    : Sequences PLL reset, waits for a stable lock, releases system reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
    parameter int RST_HOLD    = 16,
    parameter int STABLE_CYC  = 1024,
    parameter int TIMEOUT_CYC = 65535,
    parameter int MAX_RETRY   = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pll_lock_supervisor_if.slave        bus
);

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [15:0] C_HOLD_LAST    = 16'(RST_HOLD - 1);
    localparam logic [15:0] C_STABLE_LAST  = 16'(STABLE_CYC - 1);
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  C_MAX_RETRY    = 4'(MAX_RETRY);

    logic [1:0]  r_sync;
    logic        w_lock_s;
    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_retry;
    logic [3:0]  w_next_retry;
    logic        w_clr_cnt;
    logic        r_pll_resetb;
    logic        r_sys_rst_n;
    logic        r_locked;
    logic        r_fault;

    // Raw lock is asynchronous to clk; only the second flop is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.pll_lock};
        end
    end

    assign w_lock_s = r_sync[1];

    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        w_clr_cnt    = 1'b0;
        case (r_state)
            S_HOLD: begin
                if (bus.relock_req) begin
                    w_clr_cnt    = 1'b1;
                    w_next_retry = 4'd0;
                end else if (r_cnt == C_HOLD_LAST) begin
                    w_next_state = S_WAIT;
                    w_clr_cnt    = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.relock_req) begin
                    w_next_state = S_HOLD;
                    w_clr_cnt    = 1'b1;
                    w_next_retry = 4'd0;
                end else if (w_lock_s) begin
                    // Lock takes priority even on the timeout cycle.
                    w_next_state = S_STABLE;
                    w_clr_cnt    = 1'b1;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_clr_cnt = 1'b1;
                    if (r_retry == C_MAX_RETRY) begin
                        w_next_state = S_FAULT;
                    end else begin
                        w_next_state = S_HOLD;
                        w_next_retry = r_retry + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (bus.relock_req) begin
                    w_next_state = S_HOLD;
                    w_clr_cnt    = 1'b1;
                    w_next_retry = 4'd0;
                end else if (!w_lock_s) begin
                    w_next_state = S_WAIT;
                    w_clr_cnt    = 1'b1;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_next_state = S_RUN;
                    w_clr_cnt    = 1'b1;
                    w_next_retry = 4'd0;
                end
            end
            S_RUN: begin
                if (bus.relock_req || !w_lock_s) begin
                    w_next_state = S_HOLD;
                    w_clr_cnt    = 1'b1;
                    w_next_retry = 4'd0;
                end
            end
            S_FAULT: begin
                if (bus.relock_req) begin
                    w_next_state = S_HOLD;
                    w_clr_cnt    = 1'b1;
                    w_next_retry = 4'd0;
                end
            end
            default: begin
                w_next_state = S_HOLD;
                w_clr_cnt    = 1'b1;
                w_next_retry = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_HOLD;
            r_cnt        <= 16'd0;
            r_retry      <= 4'd0;
            r_pll_resetb <= 1'b0;
            r_sys_rst_n  <= 1'b0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_retry <= w_next_retry;
            if (w_clr_cnt) begin
                r_cnt <= 16'd0;
            end else if (r_state == S_HOLD || r_state == S_WAIT || r_state == S_STABLE) begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_pll_resetb <= (w_next_state == S_WAIT) || (w_next_state == S_STABLE) ||
                            (w_next_state == S_RUN);
            r_sys_rst_n  <= (w_next_state == S_RUN);
            r_locked     <= (w_next_state == S_RUN);
            r_fault      <= (w_next_state == S_FAULT);
        end
    end

    assign bus.pll_resetb = r_pll_resetb;
    assign bus.sys_rst_n  = r_sys_rst_n;
    assign bus.locked     = r_locked;
    assign bus.fault      = r_fault;
    assign bus.retry_cnt  = r_retry;
    assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
//  Module   : tb_pll_lock_supervisor
//  Brief    : Vector table, corner sequences and random run against a phase/timer model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

    localparam int RST_HOLD    = 4;
    localparam int STABLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 20;
    localparam int MAX_RETRY   = 2;

    localparam int PH_HOLD   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAULT  = 4;

    logic clk;
    logic rst_n;

    pll_lock_supervisor_if bus();

    pll_lock_supervisor #(
        .RST_HOLD    (RST_HOLD),
        .STABLE_CYC  (STABLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, retry_cnt, pll_resetb, sys_rst_n, locked, fault}
    logic [10:0] dut_o;
    assign dut_o = {bus.state, bus.retry_cnt, bus.pll_resetb, bus.sys_rst_n, bus.locked, bus.fault};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (state,retry,resetb,sysrst,locked,fault)",
                     name, act, exp);
        end
    endtask

    // Reference model: phase plus a countdown of cycles remaining in that phase.
    int   m_ph;
    int   m_left;
    int   m_retry;
    logic m_dly[$];

    task automatic model_reset();
        m_ph    = PH_HOLD;
        m_left  = RST_HOLD;
        m_retry = 0;
        m_dly   = {1'b0, 1'b0};
    endtask

    task automatic enter_hold(input bit clear_retry);
        m_ph   = PH_HOLD;
        m_left = RST_HOLD;
        if (clear_retry) m_retry = 0;
    endtask

    task automatic model_step(input logic lk, input logic rq);
        logic ls;
        ls = m_dly[1];
        m_dly.push_front(lk);
        void'(m_dly.pop_back());
        case (m_ph)
            PH_HOLD: begin
                if (rq) enter_hold(1'b1);
                else begin
                    m_left--;
                    if (m_left == 0) begin m_ph = PH_WAIT; m_left = TIMEOUT_CYC; end
                end
            end
            PH_WAIT: begin
                if (rq) enter_hold(1'b1);
                else if (ls) begin m_ph = PH_STABLE; m_left = STABLE_CYC; end
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_retry == MAX_RETRY) m_ph = PH_FAULT;
                        else begin m_retry++; enter_hold(1'b0); end
                    end
                end
            end
            PH_STABLE: begin
                if (rq) enter_hold(1'b1);
                else if (!ls) begin m_ph = PH_WAIT; m_left = TIMEOUT_CYC; end
                else begin
                    m_left--;
                    if (m_left == 0) begin m_ph = PH_RUN; m_retry = 0; end
                end
            end
            PH_RUN:  if (rq || !ls) enter_hold(1'b1);
            default: if (rq) enter_hold(1'b1);
        endcase
    endtask

    function automatic logic [10:0] model_outs();
        logic [2:0] st;
        logic [3:0] rt;
        logic       run;
        logic       on;
        st  = 3'(m_ph);
        rt  = 4'(m_retry);
        run = (m_ph == PH_RUN);
        on  = (m_ph == PH_WAIT) || (m_ph == PH_STABLE) || (m_ph == PH_RUN);
        return {st, rt, on, run, run, m_ph == PH_FAULT};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(bus.pll_lock, bus.relock_req);
        chk("model", dut_o, model_outs());
    endtask

    // Called 1 time unit after a rising edge: asserts reset between edges.
    task automatic reset_pulse(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        chk(name, dut_o, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       lk;
        logic       rq;
        int         n;
        logic [2:0] st;
        logic [3:0] rt;
        logic       rb;
        logic       sr;
        logic       fl;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b1;
        bus.relock_req = 1'b0;
        model_reset();

        tbl.push_back('{1'b1, 1'b0,  3, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  1, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  1, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  7, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  1, 3'd3, 4'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  5, 3'd3, 4'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1,  1, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  4, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0,  3, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 20, 3'd0, 4'd1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0,  4, 3'd1, 4'd1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 20, 3'd0, 4'd2, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0,  4, 3'd1, 4'd2, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 20, 3'd4, 4'd2, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 10, 3'd4, 4'd2, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1,  1, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  4, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  1, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  8, 3'd3, 4'd0, 1'b1, 1'b1, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        reset_pulse("reset_initial");

        foreach (tbl[i]) begin
            bus.pll_lock   = tbl[i].lk;
            bus.relock_req = tbl[i].rq;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d", i), dut_o,
                {tbl[i].st, tbl[i].rt, tbl[i].rb, tbl[i].sr, tbl[i].sr, tbl[i].fl});
        end
        bus.relock_req = 1'b0;

        // Three-cycle lock glitch midway through STABLE.
        bus.pll_lock = 1'b1;
        tick();
        reset_pulse("reset_before_glitch");
        repeat (9) tick();
        bus.pll_lock = 1'b0;
        repeat (3) tick();
        chk("glitch_back_to_wait", dut_o, {3'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        bus.pll_lock = 1'b1;
        repeat (10) tick();
        chk("glitch_full_stable", dut_o, {3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        tick();
        chk("glitch_run", dut_o, {3'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0});

        // Loss of lock in RUN, seen through the synchronizer.
        bus.pll_lock = 1'b0;
        repeat (2) tick();
        chk("loss_sync_delay", dut_o, {3'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        tick();
        chk("loss_hold", dut_o, {3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (3) tick();
        chk("loss_hold_last", dut_o, {3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        tick();
        chk("loss_wait", dut_o, {3'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Lock loss and relock together in RUN.
        bus.pll_lock = 1'b1;
        tick();
        reset_pulse("reset_before_dual");
        repeat (13) tick();
        bus.pll_lock   = 1'b0;
        repeat (2) tick();
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        chk("dual_exit_run", dut_o, {3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset in STABLE and in RUN.
        bus.pll_lock = 1'b1;
        tick();
        reset_pulse("reset_before_async");
        repeat (7) tick();
        chk("pre_async_stable", dut_o, {3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        reset_pulse("async_in_stable");
        repeat (13) tick();
        chk("pre_async_run", dut_o, {3'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        reset_pulse("async_in_run");

        // Random lock activity and occasional relock requests.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) bus.pll_lock = ~bus.pll_lock;
            bus.relock_req = ($urandom_range(0, 149) == 0);
            tick();
        end
        bus.relock_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
